// File: rtl/tester_pkg.sv
// Shared encodings and defaults for the board tester sequencers.
// State codes are plain localparams so legacy blocks can reuse them unchanged.
package tester_pkg;

    localparam int NUM_BITS_DEF = 128;
    localparam int DIV_DEF      = 4;
    localparam int CNT_W_DEF    = 8;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CLR     = 4'd1;
    localparam logic [3:0] ST_LATCH_H = 4'd2;
    localparam logic [3:0] ST_LATCH_L = 4'd3;
    localparam logic [3:0] ST_LOAD_L  = 4'd4;
    localparam logic [3:0] ST_LOAD_H  = 4'd5;
    localparam logic [3:0] ST_SHIFT_H = 4'd6;
    localparam logic [3:0] ST_SHIFT_L = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

endpackage

// File: rtl/phase_timer.sv
// Down-counter reloaded to DIV-1 on every state change; expired marks the last clock of a phase.
// Zero latency from counter to expired; the owner decides when to reload.
module phase_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic expired
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] RELOAD_VAL = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/output_buffer_reader.sv
// Sequences a 74HC597-style PISO chain (clear, latch, load, shift) and assembles one NUM_BITS snapshot.
// DATA_VALID pulses 5*DIV + 2*DIV*(NUM_BITS-1) + 1 clocks after START is accepted; START while BUSY is dropped.
module output_buffer_reader
    import tester_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic                Q,
    output logic                MR_BAR,
    output logic                STCP,
    output logic                PL_BAR,
    output logic                SHCP,
    output logic                BUSY,
    output logic [NUM_BITS-1:0] DATA,
    output logic                DATA_VALID
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    logic [3:0]          state_q, state_d;
    logic [NUM_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic                mr_bar_q, mr_bar_d;
    logic                stcp_q, stcp_d;
    logic                pl_bar_q, pl_bar_d;
    logic                shcp_q, shcp_d;
    logic                busy_q, busy_d;
    logic                dv_q, dv_d;
    logic                phase_done;

    phase_timer #(
        .DIV (DIV)
    ) u_phase_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .reload  (state_d != state_q),
        .expired (phase_done)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (state_q == ST_IDLE) begin
            if (START) begin
                state_d = ST_CLR;
            end
        end else if (ABORT || state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (phase_done) begin
            case (state_q)
                ST_CLR:     state_d = ST_LATCH_H;
                ST_LATCH_H: state_d = ST_LATCH_L;
                ST_LATCH_L: state_d = ST_LOAD_L;
                ST_LOAD_L:  state_d = ST_LOAD_H;
                ST_LOAD_H: begin
                    sr_d      = {sr_q[NUM_BITS-2:0], Q};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT_H;
                end
                ST_SHIFT_H: state_d = ST_SHIFT_L;
                ST_SHIFT_L: begin
                    sr_d      = {sr_q[NUM_BITS-2:0], Q};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    // Compare before increment so NUM_BITS == 2^CNT_W cannot wrap.
                    state_d   = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_SHIFT_H;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Pins are decoded from the next state so every output is a plain flop.
    always_comb begin
        mr_bar_d = (state_d != ST_CLR);
        stcp_d   = (state_d == ST_LATCH_H);
        pl_bar_d = (state_d != ST_LOAD_L);
        shcp_d   = (state_d == ST_SHIFT_H);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        dv_d     = (state_d == ST_DONE);
        data_d   = (state_d == ST_DONE) ? sr_d : data_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            mr_bar_q  <= 1'b1;
            stcp_q    <= 1'b0;
            pl_bar_q  <= 1'b1;
            shcp_q    <= 1'b0;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            mr_bar_q  <= mr_bar_d;
            stcp_q    <= stcp_d;
            pl_bar_q  <= pl_bar_d;
            shcp_q    <= shcp_d;
            busy_q    <= busy_d;
            dv_q      <= dv_d;
        end
    end

    assign MR_BAR     = mr_bar_q;
    assign STCP       = stcp_q;
    assign PL_BAR     = pl_bar_q;
    assign SHCP       = shcp_q;
    assign BUSY       = busy_q;
    assign DATA       = data_q;
    assign DATA_VALID = dv_q;

endmodule

// File: tb/tb_output_buffer_reader.sv
// Three reader instances (8b/DIV1, 8b/DIV3, 128b/DIV2), each driving a behavioural 74HC597 chain.
module tb_output_buffer_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [2:0] abort_v = 3'b000;

    always #5 clk = ~clk;

    logic         mr0, stcp0, pl0, shcp0, busy0, dv0, q0;
    logic         mr1, stcp1, pl1, shcp1, busy1, dv1, q1;
    logic         mr2, stcp2, pl2, shcp2, busy2, dv2, q2;
    logic [7:0]   data0, data1;
    logic [127:0] data2;

    output_buffer_reader #(.NUM_BITS(8), .DIV(1), .CNT_W(8)) u_dut0 (
        .CLK(clk), .RST(rst_n), .START(start_v[0]), .ABORT(abort_v[0]), .Q(q0),
        .MR_BAR(mr0), .STCP(stcp0), .PL_BAR(pl0), .SHCP(shcp0), .BUSY(busy0),
        .DATA(data0), .DATA_VALID(dv0));

    output_buffer_reader #(.NUM_BITS(8), .DIV(3), .CNT_W(8)) u_dut1 (
        .CLK(clk), .RST(rst_n), .START(start_v[1]), .ABORT(abort_v[1]), .Q(q1),
        .MR_BAR(mr1), .STCP(stcp1), .PL_BAR(pl1), .SHCP(shcp1), .BUSY(busy1),
        .DATA(data1), .DATA_VALID(dv1));

    output_buffer_reader #(.NUM_BITS(128), .DIV(2), .CNT_W(8)) u_dut2 (
        .CLK(clk), .RST(rst_n), .START(start_v[2]), .ABORT(abort_v[2]), .Q(q2),
        .MR_BAR(mr2), .STCP(stcp2), .PL_BAR(pl2), .SHCP(shcp2), .BUSY(busy2),
        .DATA(data2), .DATA_VALID(dv2));

    // Board models: STCP latches the pattern, PL_BAR loads it, SHCP shifts toward Q (MSB first).
    logic [7:0]   pat0 = '0, stor0, sh0;
    logic [7:0]   pat1 = '0, stor1, sh1;
    logic [127:0] pat2 = '0, stor2, sh2;
    int shcp_cnt0 = 0, shcp_cnt1 = 0, shcp_cnt2 = 0;

    always @(posedge stcp0) stor0 <= pat0;
    always @(posedge stcp1) stor1 <= pat1;
    always @(posedge stcp2) stor2 <= pat2;

    always @(posedge shcp0 or negedge pl0 or negedge mr0)
        if (!mr0) sh0 <= '0; else if (!pl0) sh0 <= stor0; else sh0 <= {sh0[6:0], 1'b0};
    always @(posedge shcp1 or negedge pl1 or negedge mr1)
        if (!mr1) sh1 <= '0; else if (!pl1) sh1 <= stor1; else sh1 <= {sh1[6:0], 1'b0};
    always @(posedge shcp2 or negedge pl2 or negedge mr2)
        if (!mr2) sh2 <= '0; else if (!pl2) sh2 <= stor2; else sh2 <= {sh2[126:0], 1'b0};

    assign q0 = sh0[7];
    assign q1 = sh1[7];
    assign q2 = sh2[127];

    always @(posedge shcp0) shcp_cnt0 <= shcp_cnt0 + 1;
    always @(posedge shcp1) shcp_cnt1 <= shcp_cnt1 + 1;
    always @(posedge shcp2) shcp_cnt2 <= shcp_cnt2 + 1;

    logic [2:0] dv_v, busy_v;
    assign dv_v   = {dv2, dv1, dv0};
    assign busy_v = {busy2, busy1, busy0};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic set_pat(input int d, input logic [127:0] p);
        case (d)
            0: pat0 = p[7:0];
            1: pat1 = p[7:0];
            default: pat2 = p;
        endcase
    endtask

    function automatic logic [127:0] get_data(input int d);
        case (d)
            0: return {120'b0, data0};
            1: return {120'b0, data1};
            default: return data2;
        endcase
    endfunction

    function automatic int get_shcp(input int d);
        case (d)
            0: return shcp_cnt0;
            1: return shcp_cnt1;
            default: return shcp_cnt2;
        endcase
    endfunction

    // {MR_BAR, STCP, PL_BAR, SHCP, BUSY, DATA_VALID} of instance 0
    function automatic logic [5:0] status0();
        return {mr0, stcp0, pl0, shcp0, busy0, dv0};
    endfunction

    // Pulses START for one clock; returns at the negedge of clock 1 after the accept edge.
    task automatic start_pulse(input int d);
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    // n is the current clock index; advances until DATA_VALID or the limit. n=0 means timeout.
    task automatic wait_dv(input int d, inout int n, input int limit);
        while (!dv_v[d] && n <= limit) begin
            @(negedge clk);
            n++;
        end
        if (!dv_v[d]) n = 0;
    endtask

    task automatic capture(input int d, input logic [127:0] p, input int lat, input int sh, input string tag);
        int n;
        int sh_before;
        set_pat(d, p);
        sh_before = get_shcp(d);
        start_pulse(d);
        n = 1;
        wait_dv(d, n, lat + 50);
        chk({tag, " latency"}, n, lat);
        chk({tag, " data"}, get_data(d), p);
        chk({tag, " busy at valid"}, busy_v[d], 1'b0);
        chk({tag, " shcp edges"}, get_shcp(d) - sh_before, sh);
        @(negedge clk);
    endtask

    typedef struct {
        int           d;
        logic [127:0] pat;
        int           lat;
        int           sh;
    } vec_t;

    vec_t       vecs[5];
    logic [5:0] strobe_exp[6];

    initial begin
        int n, n1, cnt;
        bit ok0, ok1, ok2;

        vecs[0] = '{0, 128'hA5, 20, 7};
        vecs[1] = '{1, 128'h3C, 58, 7};
        vecs[2] = '{2, 128'h1, 519, 127};
        vecs[3] = '{2, 128'h1 << 127, 519, 127};
        vecs[4] = '{0, 128'h5A, 20, 7};

        strobe_exp[0] = 6'b001010;  // CLR
        strobe_exp[1] = 6'b111010;  // LATCH_H
        strobe_exp[2] = 6'b101010;  // LATCH_L
        strobe_exp[3] = 6'b100010;  // LOAD_L
        strobe_exp[4] = 6'b101010;  // LOAD_H
        strobe_exp[5] = 6'b101110;  // SHIFT_H

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ok0 = 1'b1; ok1 = 1'b1; ok2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({mr0, stcp0, pl0, shcp0, busy0, dv0} !== 6'b101000 || data0 !== '0) ok0 = 1'b0;
            if ({mr1, stcp1, pl1, shcp1, busy1, dv1} !== 6'b101000 || data1 !== '0) ok1 = 1'b0;
            if ({mr2, stcp2, pl2, shcp2, busy2, dv2} !== 6'b101000 || data2 !== '0) ok2 = 1'b0;
        end
        chk("idle outputs dut0", ok0, 1'b1);
        chk("idle outputs dut1", ok1, 1'b1);
        chk("idle outputs dut2", ok2, 1'b1);

        for (int v = 0; v < 5; v++)
            capture(vecs[v].d, vecs[v].pat, vecs[v].lat, vecs[v].sh, $sformatf("vec%0d", v));

        // Strobe sequence, DIV=1, followed by a full A5 capture.
        set_pat(0, 128'hA5);
        start_pulse(0);
        n = 1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("strobe clock %0d", i + 1), status0(), strobe_exp[i]);
            @(negedge clk);
            n++;
        end
        wait_dv(0, n, 70);
        chk("strobe run latency", n, 20);
        chk("strobe run data", data0, 8'hA5);
        @(negedge clk);

        // Abort part way through shifting an FF capture.
        set_pat(0, 128'hFF);
        start_pulse(0);
        repeat (11) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("abort status", status0(), 6'b101000);
        chk("abort keeps data", data0, 8'hA5);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (dv0) cnt++;
            @(negedge clk);
        end
        chk("abort no valid", cnt, 0);
        capture(0, 128'hFF, 20, 7, "after abort");

        // START while busy is dropped.
        set_pat(0, 128'h81);
        start_pulse(0);
        repeat (4) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (dv0) cnt++;
            @(negedge clk);
        end
        chk("busy start ignored", cnt, 1);
        chk("busy start data", data0, 8'h81);

        // START held through DONE: back-to-back with one idle clock.
        set_pat(0, 128'h66);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        n = 1;
        wait_dv(0, n, 70);
        n1 = n;
        chk("b2b first latency", n1, 20);
        @(negedge clk);
        n++;
        wait_dv(0, n, 120);
        start_v[0] = 1'b0;
        chk("b2b spacing", (n == 0) ? 0 : n - n1, 21);
        chk("b2b data", data0, 8'h66);
        @(negedge clk);

        // START and ABORT together in IDLE: START wins.
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("start beats abort", busy0, 1'b1);
        n = 1;
        wait_dv(0, n, 70);
        chk("start beats abort latency", n, 20);
        @(negedge clk);

        // Asynchronous reset in SHIFT_H, between clock edges.
        set_pat(0, 128'hFF);
        start_pulse(0);
        repeat (5) @(negedge clk);
        chk("pre-reset shcp", shcp0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset status", status0(), 6'b101000);
        chk("async reset data", data0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/output_buffer_reader.md
Name: output_buffer_reader

Overview:
Sequences the board's chain of parallel-in/serial-out output-buffer shift registers (74HC597-style) to capture one snapshot of the DUT outputs. It drives MR_BAR, STCP, PL_BAR and SHCP, and samples the serial Q line. It delivers the assembled word to the central tester FSM with a start/valid handshake. It sits between the central FSM and the board-level MR_BAR/PL_BAR/STCP/SHCP/Q pins.

Parameters:
NUM_BITS, 128, total buffer-chain length in bits (DATA width); legal range is ≥2.
DIV, 4, clocks per strobe phase (each high or low half of MR/STCP/PL/SHCP); legal range is ≥1.
CNT_W, 8, width of the bit counter; must satisfy 2^CNT_W ≥ NUM_BITS.

Ports:
CLK  input  1  system clock.
RST  input  1  asynchronous, active-low reset.
START  input  1  request one capture; accepted only while BUSY=0.
ABORT  input  1  cancel the capture in progress.
Q  input  1  serial output of the last buffer in the chain.
MR_BAR  output  1  shift-register master reset, active-low.
STCP  output  1  storage-register clock; a rising edge latches the parallel inputs.
PL_BAR  output  1  parallel load (storage to shift register), active-low.
SHCP  output  1  shift clock; a rising edge advances the chain.
BUSY  output  1  high from the START-accepting edge until return to IDLE.
DATA  output  NUM_BITS  captured word; bit NUM_BITS-1 is the first bit read from Q.
DATA_VALID  output  1  one-clock pulse when DATA is updated.

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous, active-low.
- Reset values: MR_BAR=1, PL_BAR=1, STCP=0, SHCP=0, BUSY=0, DATA_VALID=0, DATA=0. State returns to IDLE.
- All pin outputs are registered, so they are glitch-free. Q is sampled directly, with no synchroniser; settle time is guaranteed by the DIV phase length.
- Phase timer: a down-counter reloaded to DIV-1 on every state change. A state advances when the counter reaches 0, so each state lasts exactly DIV clocks.
- States and outputs:
  - IDLE: all strobes inactive. START=1 → CLR, BUSY←1.
  - CLR: MR_BAR=0 → LATCH_H.
  - LATCH_H: STCP=1 → LATCH_L.
  - LATCH_L: STCP=0 → LOAD_L.
  - LOAD_L: PL_BAR=0 → LOAD_H.
  - LOAD_H: PL_BAR=1. In its last clock, shift Q in (sr ← {sr[NUM_BITS-2:0],Q}) and set bit count=1 → SHIFT_H.
  - SHIFT_H: SHCP=1 → SHIFT_L.
  - SHIFT_L: SHCP=0. In its last clock, shift Q in and increment count. If count==NUM_BITS → DONE; otherwise → SHIFT_H.
  - DONE (1 clock): DATA←sr, DATA_VALID=1, BUSY←0 → IDLE.
- Pulse count: exactly NUM_BITS Q samples and NUM_BITS-1 SHCP rising edges per capture. There is no extra shift after the last bit.
- Latency: DATA_VALID is high in clock number 5·DIV + 2·DIV·(NUM_BITS-1) + 1 after the START-accepting edge.
- START while BUSY=1: ignored, not queued.
- START held high through DONE: a new capture begins in the clock after IDLE is re-entered, giving back-to-back captures with 1 idle clock.
- ABORT=1 in any non-IDLE state: next clock goes to IDLE with strobes inactive and BUSY=0. No DATA_VALID is issued and DATA keeps its previous value. ABORT has priority over phase advance. ABORT in IDLE has no effect; if START and ABORT are both high in IDLE, START wins.
- RST low mid-capture: immediate return to reset values, including DATA=0.
- The internal shift accumulator sr is not cleared between captures. Every bit is overwritten before DONE, so no stale bits can reach DATA.

Decomposition:
- Shared package tester_pkg holds:
  - the state encoding localparams (IDLE, CLR, LATCH_H, LATCH_L, LOAD_L, LOAD_H, SHIFT_H, SHIFT_L, DONE);
  - the default NUM_BITS=128, matching the SIGNALS width;
  - the default DIV.
- One sub-module, phase_timer, provides DIV-parameterised reload/expire logic. It is reusable by the SRAM and counter sequencers.

Test Plan:
- Reset/idle, NUM_BITS=8, DIV=1: after RST release all outputs hold reset values for 20 clocks. START pulse → BUSY=1 next clock; MR_BAR low 1 clock, then STCP high 1 clock, then PL_BAR low 1 clock.
- Data order: board model loaded with 8'hA5, NUM_BITS=8, DIV=1 → exactly 7 SHCP rising edges; DATA=8'hA5 with DATA_VALID in clock 20 after accept; BUSY=0 the same clock.
- Phase stretch, DIV=3, model pattern 8'h3C: each strobe phase measures 3 clocks → DATA=8'h3C with DATA_VALID in clock 58.
- Full width, NUM_BITS=128, DIV=2, walking-one at bit 0 then bit 127 → DATA equals the pattern each time; 127 SHCP edges per capture.
- ABORT at bit 4 of a 8'hFF capture → IDLE next clock, no DATA_VALID, DATA retains the prior 8'hA5. A following START captures 8'hFF correctly.
- START while busy is ignored: DATA_VALID count stays 1. Async RST low mid-SHIFT_H → SHCP=0, BUSY=0, DATA=0 immediately, without waiting for a clock edge.
